// File: rtl/riscv_pipeline_pkg.sv
// Shared pipeline definitions: base-ISA opcodes, the packed control bundle
// carried from decode into execute, and operand-usage helpers per opcode.
package riscv_pipeline_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic       aluSrc1;
        logic       aluSrc2;
        logic [3:0] aluOperation;
        logic       pcAdderSrc;
        logic       pcUpdate;
        logic       writeBackFromAluOrMemory;
    } ctrl_t;

    // All-zero bundle: no memory access, no register write-back.
    localparam ctrl_t CTRL_NOP = '0;

    // Unknown opcodes are treated as reading rs1 so a hazard is never missed.
    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {OP_R, OP_STORE, OP_BRANCH};
    endfunction

endpackage

// File: rtl/load_use_hazard_detector.sv
// Combinational load-use detector: flags a decode instruction that reads the
// destination of a load currently sitting in the execute slot.
module load_use_hazard_detector
    import riscv_pipeline_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [6:0]                opcode,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    input  logic                      decodeValid,
    input  logic [REG_ADDR_WIDTH-1:0] executeRd,
    input  logic                      executeMemRead,
    input  logic                      executeValid,
    output logic                      loadUseHazard
);

    logic load_in_execute;
    logic rs1_match;
    logic rs2_match;

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign load_in_execute = executeValid && executeMemRead && (executeRd != '0);
    assign rs1_match       = uses_rs1(opcode) && (rs1 == executeRd);
    assign rs2_match       = uses_rs2(opcode) && (rs2 == executeRd);
    assign loadUseHazard   = load_in_execute && decodeValid && (rs1_match || rs2_match);

endmodule

// File: rtl/decode_execute_stage.sv
// Decode-to-execute pipeline register with load-use bubble insertion, execute
// stall hold and flush. Optional saturating hazard counters: HAZARD_COUNTER_EN.
module decode_execute_stage
    import riscv_pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNTER_WIDTH  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      decodeValid,
    input  logic                      flush,
    input  logic                      executeStall,
    input  logic [6:0]                opcode,
    input  logic [DATA_WIDTH-1:0]     pcIn,
    input  logic [DATA_WIDTH-1:0]     readData1,
    input  logic [DATA_WIDTH-1:0]     readData2,
    input  logic [DATA_WIDTH-1:0]     immediateValue,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic [2:0]                funct3,
    input  logic [6:0]                funct7,
    input  ctrl_t                     ctrlIn,
    output logic                      executeValid,
    output logic [DATA_WIDTH-1:0]     pcOut,
    output logic [DATA_WIDTH-1:0]     readData1Out,
    output logic [DATA_WIDTH-1:0]     readData2Out,
    output logic [DATA_WIDTH-1:0]     immediateOut,
    output logic [REG_ADDR_WIDTH-1:0] rs1Out,
    output logic [REG_ADDR_WIDTH-1:0] rs2Out,
    output logic [REG_ADDR_WIDTH-1:0] rdOut,
    output logic [2:0]                funct3Out,
    output logic [6:0]                funct7Out,
    output ctrl_t                     ctrlOut,
    output logic                      decodeStall,
    output logic                      loadUseHazard
`ifdef HAZARD_COUNTER_EN
    ,
    output logic [COUNTER_WIDTH-1:0]  stallCount,
    output logic [COUNTER_WIDTH-1:0]  flushCount
`endif
);

    if (COUNTER_WIDTH < 1) begin : g_counter_width_check
        $error("COUNTER_WIDTH must be at least 1");
    end

    load_use_hazard_detector #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard (
        .opcode         (opcode),
        .rs1            (rs1),
        .rs2            (rs2),
        .decodeValid    (decodeValid),
        .executeRd      (rdOut),
        .executeMemRead (ctrlOut.memRead),
        .executeValid   (executeValid),
        .loadUseHazard  (loadUseHazard)
    );

    // A flush discards the decode slot, so there is nothing left to hold upstream.
    assign decodeStall = !flush && (executeStall || loadUseHazard);

    always_ff @(posedge clock) begin
        if (reset) begin
            executeValid <= 1'b0;
            pcOut        <= '0;
            readData1Out <= '0;
            readData2Out <= '0;
            immediateOut <= '0;
            rs1Out       <= '0;
            rs2Out       <= '0;
            rdOut        <= '0;
            funct3Out    <= '0;
            funct7Out    <= '0;
            ctrlOut      <= CTRL_NOP;
        end else if (flush) begin
            executeValid <= 1'b0;
            ctrlOut      <= CTRL_NOP;
        end else if (!executeStall) begin
            // Data fields are captured even on a bubble; the cleared valid and
            // control bundle make them inert downstream.
            pcOut        <= pcIn;
            readData1Out <= readData1;
            readData2Out <= readData2;
            immediateOut <= immediateValue;
            rs1Out       <= rs1;
            rs2Out       <= rs2;
            rdOut        <= rd;
            funct3Out    <= funct3;
            funct7Out    <= funct7;
            if (loadUseHazard) begin
                executeValid <= 1'b0;
                ctrlOut      <= CTRL_NOP;
            end else begin
                executeValid <= decodeValid;
                ctrlOut      <= decodeValid ? ctrlIn : CTRL_NOP;
            end
        end
    end

`ifdef HAZARD_COUNTER_EN
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (decodeStall && (stallCount != '1)) begin
                stallCount <= stallCount + CNT_ONE;
            end
            // Only flushes that actually kill a real instruction are counted.
            if (flush && decodeValid && (flushCount != '1)) begin
                flushCount <= flushCount + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_execute_stage.sv
// Self-checking bench for decode_execute_stage: directed scenarios plus a
// randomized run against a behavioural slot model (counters with HAZARD_COUNTER_EN).
module tb_decode_execute_stage;
    import riscv_pipeline_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam ctrl_t CTRL_ADD = '{regWrite: 1'b1, default: '0};
    localparam ctrl_t CTRL_LW  = '{memRead: 1'b1, regWrite: 1'b1, aluSrc2: 1'b1,
                                   writeBackFromAluOrMemory: 1'b1, default: '0};

    logic        clock;
    logic        reset;
    logic        decodeValid;
    logic        flush;
    logic        executeStall;
    logic [6:0]  opcode;
    logic [31:0] pcIn;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] immediateValue;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    ctrl_t       ctrlIn;
    logic        executeValid;
    logic [31:0] pcOut;
    logic [31:0] readData1Out;
    logic [31:0] readData2Out;
    logic [31:0] immediateOut;
    logic [4:0]  rs1Out;
    logic [4:0]  rs2Out;
    logic [4:0]  rdOut;
    logic [2:0]  funct3Out;
    logic [6:0]  funct7Out;
    ctrl_t       ctrlOut;
    logic        decodeStall;
    logic        loadUseHazard;
`ifdef HAZARD_COUNTER_EN
    logic [CW-1:0] stallCount;
    logic [CW-1:0] flushCount;
`endif

    int checks = 0;
    int errors = 0;

    decode_execute_stage #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .COUNTER_WIDTH  (CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .decodeValid    (decodeValid),
        .flush          (flush),
        .executeStall   (executeStall),
        .opcode         (opcode),
        .pcIn           (pcIn),
        .readData1      (readData1),
        .readData2      (readData2),
        .immediateValue (immediateValue),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .funct3         (funct3),
        .funct7         (funct7),
        .ctrlIn         (ctrlIn),
        .executeValid   (executeValid),
        .pcOut          (pcOut),
        .readData1Out   (readData1Out),
        .readData2Out   (readData2Out),
        .immediateOut   (immediateOut),
        .rs1Out         (rs1Out),
        .rs2Out         (rs2Out),
        .rdOut          (rdOut),
        .funct3Out      (funct3Out),
        .funct7Out      (funct7Out),
        .ctrlOut        (ctrlOut),
        .decodeStall    (decodeStall),
        .loadUseHazard  (loadUseHazard)
`ifdef HAZARD_COUNTER_EN
        ,
        .stallCount     (stallCount),
        .flushCount     (flushCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Operand usage as defined by the ISA, independent of the RTL helpers.
    function automatic logic ref_reads_rs1(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL: return 1'b0;
            default:                  return 1'b1;
        endcase
    endfunction

    function automatic logic ref_reads_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_STORE, OP_BRANCH: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        decodeValid    = 1'b0;
        flush          = 1'b0;
        executeStall   = 1'b0;
        opcode         = OP_IMM;
        pcIn           = '0;
        readData1      = '0;
        readData2      = '0;
        immediateValue = '0;
        rs1            = '0;
        rs2            = '0;
        rd             = '0;
        funct3         = '0;
        funct7         = '0;
        ctrlIn         = CTRL_NOP;
    endtask

    task automatic drive(input logic [6:0] op, input logic [31:0] pc, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rdv, input ctrl_t c);
        decodeValid    = 1'b1;
        opcode         = op;
        pcIn           = pc;
        rs1            = r1;
        rs2            = r2;
        rd             = rdv;
        ctrlIn         = c;
        readData1      = $urandom;
        readData2      = $urandom;
        immediateValue = $urandom;
        funct3         = 3'($urandom);
        funct7         = 7'($urandom);
    endtask

    task automatic test_reset();
        drive(OP_R, 32'hdead_beef, 5'd7, 5'd8, 5'd9, CTRL_LW);
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({executeValid, pcOut, readData1Out, readData2Out, immediateOut, rs1Out, rs2Out, rdOut,
             funct3Out, funct7Out, ctrlOut} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b pc=%h rd=%0d ctrl=%h, required all zero",
                     executeValid, pcOut, rdOut, ctrlOut);
        end
        reset = 1'b0;
        set_idle();
        #1;
        checks++;
        if (decodeStall !== 1'b0 || loadUseHazard !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: decodeStall=%0b hazard=%0b, required 0/0", decodeStall, loadUseHazard);
        end
`ifdef HAZARD_COUNTER_EN
        checks++;
        if (stallCount !== '0 || flushCount !== '0) begin
            errors++;
            $display("FAIL reset_counters: stall=%0d flush=%0d, required 0/0", stallCount, flushCount);
        end
`endif
    endtask

    task automatic test_capture();
        logic [31:0] e_d1, e_d2, e_imm;
        logic [2:0]  e_f3;
        logic [6:0]  e_f7;
        drive(OP_R, 32'h10, 5'd3, 5'd4, 5'd6, CTRL_ADD);
        e_d1 = readData1; e_d2 = readData2; e_imm = immediateValue; e_f3 = funct3; e_f7 = funct7;
        tick();
        checks++;
        if (executeValid !== 1'b1 || pcOut !== 32'h10 || ctrlOut !== CTRL_ADD) begin
            errors++;
            $display("FAIL capture_basic: valid=%0b pc=%h ctrl=%h, required 1/00000010/%h",
                     executeValid, pcOut, ctrlOut, CTRL_ADD);
        end
        checks++;
        if ({readData1Out, readData2Out, immediateOut, rs1Out, rs2Out, rdOut, funct3Out, funct7Out} !==
            {e_d1, e_d2, e_imm, 5'd3, 5'd4, 5'd6, e_f3, e_f7}) begin
            errors++;
            $display("FAIL capture_fields: d1=%h d2=%h imm=%h rs1=%0d rd=%0d, required %h %h %h 3 6",
                     readData1Out, readData2Out, immediateOut, rs1Out, rdOut, e_d1, e_d2, e_imm);
        end
        drive(OP_LOAD, 32'h14, 5'd1, 5'd0, 5'd2, CTRL_LW);
        decodeValid = 1'b0;
        tick();
        checks++;
        if (executeValid !== 1'b0 || ctrlOut !== CTRL_NOP) begin
            errors++;
            $display("FAIL capture_invalid: valid=%0b ctrl=%h, required 0/000", executeValid, ctrlOut);
        end
        set_idle();
    endtask

    task automatic test_load_use();
        drive(OP_LOAD, 32'h20, 5'd1, 5'd0, 5'd5, CTRL_LW);
        tick();
        drive(OP_R, 32'h24, 5'd5, 5'd7, 5'd6, CTRL_ADD);
        #1;
        checks++;
        if (loadUseHazard !== 1'b1 || decodeStall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_detect: hazard=%0b stall=%0b, required 1/1", loadUseHazard, decodeStall);
        end
        tick();
        checks++;
        if (executeValid !== 1'b0 || ctrlOut !== CTRL_NOP) begin
            errors++;
            $display("FAIL load_use_bubble: valid=%0b ctrl=%h, required 0/000", executeValid, ctrlOut);
        end
        #1;
        checks++;
        if (loadUseHazard !== 1'b0 || decodeStall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_clear: hazard=%0b stall=%0b, required 0/0", loadUseHazard, decodeStall);
        end
        tick();
        checks++;
        if (executeValid !== 1'b1 || pcOut !== 32'h24 || ctrlOut !== CTRL_ADD || rs1Out !== 5'd5) begin
            errors++;
            $display("FAIL load_use_resume: valid=%0b pc=%h ctrl=%h rs1=%0d, required 1/00000024/%h/5",
                     executeValid, pcOut, ctrlOut, rs1Out, CTRL_ADD);
        end
        set_idle();
    endtask

    task automatic test_hazard_qualifiers();
        logic [6:0] ops  [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LOAD, OP_R};
        logic [4:0] r1s  [9] = '{5'd9, 5'd9, 5'd9, 5'd1, 5'd9, 5'd1, 5'd0, 5'd1, 5'd9};
        logic [4:0] r2s  [9] = '{5'd0, 5'd9, 5'd9, 5'd9, 5'd0, 5'd9, 5'd9, 5'd9, 5'd1};
        logic       dvs  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       exps [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        drive(OP_LOAD, 32'h50, 5'd2, 5'd0, 5'd9, CTRL_LW);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(ops[i], 32'h54, r1s[i], r2s[i], 5'd3, CTRL_ADD);
            decodeValid = dvs[i];
            #1;
            checks++;
            if (loadUseHazard !== exps[i] || decodeStall !== exps[i]) begin
                errors++;
                $display("FAIL hazard_case%0d: op=%b hazard=%0b stall=%0b, required %0b", i, ops[i],
                         loadUseHazard, decodeStall, exps[i]);
            end
        end
        drive(OP_LOAD, 32'h60, 5'd2, 5'd0, 5'd0, CTRL_LW);
        tick();
        drive(OP_R, 32'h64, 5'd0, 5'd0, 5'd4, CTRL_ADD);
        #1;
        checks++;
        if (loadUseHazard !== 1'b0 || decodeStall !== 1'b0) begin
            errors++;
            $display("FAIL hazard_x0: hazard=%0b stall=%0b, required 0/0", loadUseHazard, decodeStall);
        end
        tick();
        set_idle();
    endtask

    task automatic test_stall();
        logic [31:0] e_d1, e_imm;
        drive(OP_IMM, 32'h40, 5'd2, 5'd3, 5'd4, CTRL_ADD);
        e_d1 = readData1; e_imm = immediateValue;
        tick();
        drive(OP_R, 32'h44, 5'd5, 5'd6, 5'd7, CTRL_LW);
        executeStall = 1'b1;
        #1;
        checks++;
        if (decodeStall !== 1'b1) begin
            errors++;
            $display("FAIL stall_backpressure: decodeStall=%0b, required 1", decodeStall);
        end
        tick();
        checks++;
        if (executeValid !== 1'b1 || pcOut !== 32'h40 || ctrlOut !== CTRL_ADD || readData1Out !== e_d1 ||
            immediateOut !== e_imm || rdOut !== 5'd4) begin
            errors++;
            $display("FAIL stall_hold: valid=%0b pc=%h ctrl=%h d1=%h rd=%0d, required 1/00000040/%h/%h/4",
                     executeValid, pcOut, ctrlOut, readData1Out, rdOut, CTRL_ADD, e_d1);
        end
        executeStall = 1'b0;
        tick();
        checks++;
        if (executeValid !== 1'b1 || pcOut !== 32'h44 || ctrlOut !== CTRL_LW || rdOut !== 5'd7) begin
            errors++;
            $display("FAIL stall_release: valid=%0b pc=%h ctrl=%h rd=%0d, required 1/00000044/%h/7",
                     executeValid, pcOut, ctrlOut, rdOut, CTRL_LW);
        end
        set_idle();
        tick();
    endtask

    task automatic test_flush();
        drive(OP_LOAD, 32'h70, 5'd1, 5'd0, 5'd5, CTRL_LW);
        tick();
        drive(OP_R, 32'h74, 5'd5, 5'd2, 5'd6, CTRL_ADD);
        flush        = 1'b1;
        executeStall = 1'b1;
        #1;
        checks++;
        if (decodeStall !== 1'b0 || loadUseHazard !== 1'b1) begin
            errors++;
            $display("FAIL flush_comb: stall=%0b hazard=%0b, required 0/1", decodeStall, loadUseHazard);
        end
        tick();
        checks++;
        if (executeValid !== 1'b0 || ctrlOut !== CTRL_NOP) begin
            errors++;
            $display("FAIL flush_kill: valid=%0b ctrl=%h, required 0/000", executeValid, ctrlOut);
        end
        set_idle();
        tick();
    endtask

    task automatic test_reset_in_hazard();
        drive(OP_LOAD, 32'h80, 5'd1, 5'd0, 5'd5, CTRL_LW);
        tick();
        drive(OP_R, 32'h84, 5'd5, 5'd2, 5'd6, CTRL_ADD);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({executeValid, pcOut, readData1Out, immediateOut, rs1Out, rdOut, ctrlOut} !== '0) begin
            errors++;
            $display("FAIL reset_hazard_outputs: valid=%0b pc=%h rd=%0d ctrl=%h, required all zero",
                     executeValid, pcOut, rdOut, ctrlOut);
        end
        #1;
        checks++;
        if (decodeStall !== 1'b0) begin
            errors++;
            $display("FAIL reset_hazard_stall: decodeStall=%0b, required 0", decodeStall);
        end
        set_idle();
        tick();
    endtask

`ifdef HAZARD_COUNTER_EN
    task automatic test_counters();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        executeStall = 1'b1;
        repeat (20) tick();
        checks++;
        if (stallCount !== 4'd15) begin
            errors++;
            $display("FAIL counter_stall_sat: stallCount=%0d, required 15", stallCount);
        end
        executeStall = 1'b0;
        decodeValid  = 1'b1;
        flush        = 1'b1;
        repeat (3) tick();
        decodeValid = 1'b0;
        tick();
        checks++;
        if (flushCount !== 4'd3 || stallCount !== 4'd15) begin
            errors++;
            $display("FAIL counter_flush: flushCount=%0d stallCount=%0d, required 3/15", flushCount, stallCount);
        end
        set_idle();
        tick();
    endtask
`endif

    task automatic test_random();
        logic [6:0]  op_tab [9] = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        logic        m_valid;
        ctrl_t       m_ctrl;
        logic [31:0] m_pc, m_d1, m_d2, m_imm;
        logic [4:0]  m_rs1, m_rs2, m_rd;
        logic [2:0]  m_f3;
        logic [6:0]  m_f7;
        logic        exp_haz, exp_stall;
`ifdef HAZARD_COUNTER_EN
        int          m_stall_cnt, m_flush_cnt;
`endif
        set_idle();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        m_valid = 1'b0; m_ctrl = CTRL_NOP; m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_f7 = '0;
`ifdef HAZARD_COUNTER_EN
        m_stall_cnt = 0; m_flush_cnt = 0;
`endif
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset          = ($urandom_range(0, 49) == 0);
            flush          = ($urandom_range(0, 9) == 0);
            executeStall   = ($urandom_range(0, 6) == 0);
            decodeValid    = ($urandom_range(0, 4) != 0);
            opcode         = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_tab[$urandom_range(0, 8)];
            pcIn           = $urandom;
            readData1      = $urandom;
            readData2      = $urandom;
            immediateValue = $urandom;
            rs1            = 5'($urandom_range(0, 3));
            rs2            = 5'($urandom_range(0, 3));
            rd             = 5'($urandom_range(0, 3));
            funct3         = 3'($urandom);
            funct7         = 7'($urandom);
            ctrlIn         = ctrl_t'(12'($urandom));

            exp_haz   = m_valid && m_ctrl.memRead && (m_rd != 5'd0) && decodeValid &&
                        ((ref_reads_rs1(opcode) && rs1 == m_rd) || (ref_reads_rs2(opcode) && rs2 == m_rd));
            exp_stall = !flush && (executeStall || exp_haz);
            #1;
            if (!reset) begin
                checks++;
                if (loadUseHazard !== exp_haz || decodeStall !== exp_stall) begin
                    errors++;
                    $display("FAIL rand_comb cyc%0d: hazard=%0b stall=%0b, required %0b/%0b", cyc,
                             loadUseHazard, decodeStall, exp_haz, exp_stall);
                end
            end
            tick();

            if (reset) begin
                m_valid = 1'b0; m_ctrl = CTRL_NOP; m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
                m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_f7 = '0;
`ifdef HAZARD_COUNTER_EN
                m_stall_cnt = 0; m_flush_cnt = 0;
`endif
            end else begin
`ifdef HAZARD_COUNTER_EN
                if (exp_stall && m_stall_cnt < CMAX) m_stall_cnt++;
                if (flush && decodeValid && m_flush_cnt < CMAX) m_flush_cnt++;
`endif
                if (flush) begin
                    m_valid = 1'b0;
                    m_ctrl  = CTRL_NOP;
                end else if (!executeStall) begin
                    if (exp_haz) begin
                        m_valid = 1'b0;
                        m_ctrl  = CTRL_NOP;
                    end else begin
                        m_valid = decodeValid;
                        m_ctrl  = decodeValid ? ctrlIn : CTRL_NOP;
                        m_pc = pcIn; m_d1 = readData1; m_d2 = readData2; m_imm = immediateValue;
                        m_rs1 = rs1; m_rs2 = rs2; m_rd = rd; m_f3 = funct3; m_f7 = funct7;
                    end
                end
            end

            checks++;
            if (executeValid !== m_valid || ctrlOut !== m_ctrl) begin
                errors++;
                $display("FAIL rand_slot cyc%0d: valid=%0b ctrl=%h, required %0b/%h", cyc,
                         executeValid, ctrlOut, m_valid, m_ctrl);
            end
            if (m_valid) begin
                checks++;
                if ({pcOut, readData1Out, readData2Out, immediateOut, rs1Out, rs2Out, rdOut, funct3Out, funct7Out} !==
                    {m_pc, m_d1, m_d2, m_imm, m_rs1, m_rs2, m_rd, m_f3, m_f7}) begin
                    errors++;
                    $display("FAIL rand_data cyc%0d: pc=%h d1=%h imm=%h rd=%0d, required %h %h %h %0d", cyc,
                             pcOut, readData1Out, immediateOut, rdOut, m_pc, m_d1, m_imm, m_rd);
                end
            end
`ifdef HAZARD_COUNTER_EN
            checks++;
            if (int'(stallCount) != m_stall_cnt || int'(flushCount) != m_flush_cnt) begin
                errors++;
                $display("FAIL rand_counters cyc%0d: stall=%0d flush=%0d, required %0d/%0d", cyc,
                         stallCount, flushCount, m_stall_cnt, m_flush_cnt);
            end
`endif
        end
        reset = 1'b0;
        set_idle();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        test_reset();
        test_capture();
        test_load_use();
        test_hazard_qualifiers();
        test_stall();
        test_flush();
        test_reset_in_hazard();
`ifdef HAZARD_COUNTER_EN
        test_counters();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
